// File: rtl/gcm_gctr_frame_sequencer_if.sv
// Host/data-side and GCTR-side signal bundle for the GCM frame sequencer.
// The master modport is the host/testbench side; the slave modport is the sequencer.
interface gcm_gctr_frame_sequencer_if #(
    parameter int NB_BLOCK    = 128,
    parameter int N_BLOCKS    = 2,
    parameter int NB_DATA     = N_BLOCKS * NB_BLOCK,
    parameter int NB_IV       = 96,
    parameter int NB_LEN      = 16,
    parameter int NB_BYTE_CNT = 6
);
    logic                   i_start;
    logic [NB_IV-1:0]       i_iv;
    logic [NB_LEN-1:0]      i_n_words;
    logic [NB_BYTE_CNT-1:0] i_last_bytes;
    logic [NB_DATA-1:0]     i_data;
    logic                   i_data_valid;
    logic                   o_data_ready;
    logic                   o_sop_pre;
    logic [NB_DATA-1:0]     o_pre_blocks;
    logic                   o_sop;
    logic                   o_valid;
    logic [NB_DATA-1:0]     o_plaintext_words;
    logic [NB_BLOCK-1:0]    o_initial_counter_block;
    logic                   o_last;
    logic [NB_DATA/8-1:0]   o_last_byte_mask;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_error;

    modport master (
        output i_start, i_iv, i_n_words, i_last_bytes, i_data, i_data_valid,
        input  o_data_ready, o_sop_pre, o_pre_blocks, o_sop, o_valid, o_plaintext_words,
               o_initial_counter_block, o_last, o_last_byte_mask, o_busy, o_done, o_error
    );

    modport slave (
        input  i_start, i_iv, i_n_words, i_last_bytes, i_data, i_data_valid,
        output o_data_ready, o_sop_pre, o_pre_blocks, o_sop, o_valid, o_plaintext_words,
               o_initial_counter_block, o_last, o_last_byte_mask, o_busy, o_done, o_error
    );
endinterface

// File: rtl/gcm_gctr_frame_sequencer.sv
// Drives one GCM message into the shared GCTR pipeline: a single pre-cycle
// carrying 0^128 and J0, then the text words with SOP/LAST and a byte mask.
// Every output is a register; the combinational process computes their next values.
module gcm_gctr_frame_sequencer #(
    parameter int NB_BLOCK    = 128,
    parameter int N_BLOCKS    = 2,
    parameter int NB_DATA     = N_BLOCKS * NB_BLOCK,
    parameter int NB_IV       = 96,
    parameter int NB_LEN      = 16,
    parameter int NB_BYTE_CNT = 6
) (
    input logic                       i_clock,
    input logic                       i_reset,
    gcm_gctr_frame_sequencer_if.slave bus
);
    localparam int NB_MASK = NB_DATA / 8;
    localparam int NB_CTR  = NB_BLOCK - NB_IV;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DONE} state_t;

    state_t                 state_q, state_d;
    logic [NB_LEN-1:0]      remaining_q, remaining_d;
    logic [NB_BYTE_CNT-1:0] last_bytes_q, last_bytes_d;
    logic                   first_q, first_d;
    logic                   err_pend_q, err_pend_d;

    logic                   data_ready_q, data_ready_d;
    logic                   sop_pre_q, sop_pre_d;
    logic [NB_DATA-1:0]     pre_blocks_q, pre_blocks_d;
    logic                   sop_q, sop_d;
    logic                   valid_q, valid_d;
    logic [NB_DATA-1:0]     text_q, text_d;
    logic [NB_BLOCK-1:0]    icb_q, icb_d;
    logic                   last_q, last_d;
    logic [NB_MASK-1:0]     mask_q, mask_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   accept;
    logic                   legal;
    logic                   err_req;
    logic [NB_MASK-1:0]     word_mask;

    // Next-state and next-output computation; a rejected start becomes a pending
    // error whenever another strobe is due the same cycle so all strobes stay exclusive.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        last_bytes_d = last_bytes_q;
        first_d      = first_q;
        err_pend_d   = err_pend_q;
        data_ready_d = data_ready_q;
        sop_pre_d    = 1'b0;
        pre_blocks_d = '0;
        sop_d        = 1'b0;
        valid_d      = 1'b0;
        text_d       = text_q;
        icb_d        = icb_q;
        last_d       = 1'b0;
        mask_d       = mask_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        err_req      = 1'b0;
        word_mask    = '1;

        accept = (state_q == DATA) && data_ready_q && bus.i_data_valid;
        legal  = (bus.i_n_words == '0) ||
                 ((bus.i_last_bytes != '0) && (int'(bus.i_last_bytes) <= NB_MASK));

        case (state_q)
            IDLE: begin
                data_ready_d = 1'b0;
                if (bus.i_start) begin
                    if (legal) begin
                        state_d      = PRE;
                        remaining_d  = bus.i_n_words;
                        last_bytes_d = bus.i_last_bytes;
                        first_d      = 1'b1;
                        icb_d        = {bus.i_iv, NB_CTR'(2)};
                        sop_pre_d    = 1'b1;
                        pre_blocks_d[NB_BLOCK +: NB_BLOCK] = {bus.i_iv, NB_CTR'(1)};
                    end else begin
                        err_req = 1'b1;
                    end
                end
            end
            PRE: begin
                if (remaining_q != '0) begin
                    state_d      = DATA;
                    data_ready_d = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    if (remaining_q == NB_LEN'(1)) begin
                        for (int k = 0; k < NB_MASK; k++) begin
                            word_mask[k] = (k < int'(last_bytes_q));
                        end
                        last_d = 1'b1;
                    end
                    for (int k = 0; k < NB_MASK; k++) begin
                        text_d[8*k +: 8] = word_mask[k] ? bus.i_data[8*k +: 8] : 8'h00;
                    end
                    mask_d       = word_mask;
                    valid_d      = 1'b1;
                    sop_d        = first_q;
                    first_d      = 1'b0;
                    remaining_d  = remaining_q - NB_LEN'(1);
                    data_ready_d = (remaining_q != NB_LEN'(1));
                end else if (remaining_q == '0) begin
                    state_d      = DONE;
                    done_d       = 1'b1;
                    data_ready_d = 1'b0;
                end
            end
            DONE: begin
                state_d      = IDLE;
                data_ready_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                data_ready_d = 1'b0;
            end
        endcase

        if (state_q != IDLE && bus.i_start) begin
            err_req = 1'b1;
        end

        if (err_req || err_pend_q) begin
            if (sop_pre_d || sop_d || done_d) begin
                err_pend_d = 1'b1;
            end else begin
                error_d    = 1'b1;
                err_pend_d = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs; reset discards any message in flight.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            last_bytes_q <= '0;
            first_q      <= 1'b0;
            err_pend_q   <= 1'b0;
            data_ready_q <= 1'b0;
            sop_pre_q    <= 1'b0;
            pre_blocks_q <= '0;
            sop_q        <= 1'b0;
            valid_q      <= 1'b0;
            text_q       <= '0;
            icb_q        <= '0;
            last_q       <= 1'b0;
            mask_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            last_bytes_q <= last_bytes_d;
            first_q      <= first_d;
            err_pend_q   <= err_pend_d;
            data_ready_q <= data_ready_d;
            sop_pre_q    <= sop_pre_d;
            pre_blocks_q <= pre_blocks_d;
            sop_q        <= sop_d;
            valid_q      <= valid_d;
            text_q       <= text_d;
            icb_q        <= icb_d;
            last_q       <= last_d;
            mask_q       <= mask_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.o_data_ready            = data_ready_q;
    assign bus.o_sop_pre               = sop_pre_q;
    assign bus.o_pre_blocks            = pre_blocks_q;
    assign bus.o_sop                   = sop_q;
    assign bus.o_valid                 = valid_q;
    assign bus.o_plaintext_words       = text_q;
    assign bus.o_initial_counter_block = icb_q;
    assign bus.o_last                  = last_q;
    assign bus.o_last_byte_mask        = mask_q;
    assign bus.o_busy                  = busy_q;
    assign bus.o_done                  = done_q;
    assign bus.o_error                 = error_q;
endmodule
